bellman_sched: RTL and testbench

Controller for the Bellman-Ford engine and the adjacency matrix it reads. It buffers incoming edge-weight updates in a small FIFO and drains them into the adjacency-matrix write port only while the engine is idle. It starts engine runs on request by pulsing `bellman_reset` with a latched source vertex, then reports completion through a valid/ready handshake. Widths come from `Const.vh`: `PRED_WIDTH`, `WEIGHT_WIDTH` and `NODES`.

---
 rtl/bellman_sched_if.sv | 43 ++++
 rtl/bellman_sched.sv | 181 ++++++++++++++++++
 tb/tb_bellman_sched.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bellman_sched_if.sv
`default_nettype none
//==============================================================================
// bellman_sched_if : update, run-control and result signals of bellman_sched
// Revision: 1.0
//==============================================================================
interface bellman_sched_if #(
  parameter int PRED_WIDTH   = 3,
  parameter int WEIGHT_WIDTH = 7
);
  logic                    upd_valid;
  logic                    upd_ready;
  logic [PRED_WIDTH:0]     upd_row;
  logic [PRED_WIDTH:0]     upd_col;
  logic [WEIGHT_WIDTH:0]   upd_weight;
  logic                    run_req;
  logic [PRED_WIDTH:0]     src_in;
  logic                    adjmat_we;
  logic [PRED_WIDTH:0]     adjmat_wr_row;
  logic [PRED_WIDTH:0]     adjmat_wr_col;
  logic [WEIGHT_WIDTH:0]   adjmat_wr_data;
  logic                    bellman_reset;
  logic [PRED_WIDTH:0]     bellman_src;
  logic                    bellman_done;
  logic                    result_valid;
  logic                    result_ready;
  logic [15:0]             run_count;
  logic                    busy;

  modport master (
    output upd_valid, upd_row, upd_col, upd_weight, run_req, src_in,
           bellman_done, result_ready,
    input  upd_ready, adjmat_we, adjmat_wr_row, adjmat_wr_col, adjmat_wr_data,
           bellman_reset, bellman_src, result_valid, run_count, busy
  );

  modport slave (
    input  upd_valid, upd_row, upd_col, upd_weight, run_req, src_in,
           bellman_done, result_ready,
    output upd_ready, adjmat_we, adjmat_wr_row, adjmat_wr_col, adjmat_wr_data,
           bellman_reset, bellman_src, result_valid, run_count, busy
  );
endinterface
`default_nettype wire

// File: rtl/bellman_sched.sv
`default_nettype none
//==============================================================================
// bellman_sched : buffers adjacency-matrix updates, drains them while the
//                 Bellman-Ford engine is idle, and sequences engine runs.
// Revision: 1.0
//==============================================================================
module bellman_sched #(
  parameter int PRED_WIDTH   = 3,
  parameter int WEIGHT_WIDTH = 7,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire logic     clk,
  input  wire logic     reset,
  bellman_sched_if.slave bus
);
  localparam int VW    = PRED_WIDTH + 1;
  localparam int WW    = WEIGHT_WIDTH + 1;
  localparam int EW    = 2 * VW + WW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CAP_V   = (PTR_W + 1)'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0] ONE_V   = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    drain_cnt_q, drain_cnt_d;
  logic              run_pending_q, run_pending_d;
  logic [VW-1:0]     src_q, src_d;
  logic [VW-1:0]     bellman_src_q, bellman_src_d;
  logic [15:0]       run_count_q, run_count_d;

  logic [PTR_W:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              drain_last;
  logic              adjmat_we;
  logic              bellman_reset;
  logic              result_valid;
  logic [VW-1:0]     head_row;
  logic [VW-1:0]     head_col;
  logic [WW-1:0]     head_weight;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (fifo_count == DEPTH_V);
  assign push       = bus.upd_valid && !fifo_full;
  assign {head_row, head_col, head_weight} = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {bus.upd_row, bus.upd_col, bus.upd_weight};
    end
    wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(push);
    rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(pop);
  end

  // A concurrent push keeps the FIFO non-empty, so only a lone last pop ends the drain.
  assign drain_last = (fifo_count == ONE_V) && !push;

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    adjmat_we     = 1'b0;
    bellman_reset = 1'b0;
    result_valid  = 1'b0;
    drain_cnt_d   = drain_cnt_q;
    run_pending_d = run_pending_q;
    src_d         = src_q;
    bellman_src_d = bellman_src_q;
    run_count_d   = run_count_q;

    case (state_q)
      S_IDLE: begin
        // drain_cnt == DEPTH marks a drain cut short for a waiting run.
        if (run_pending_q && (drain_cnt_q == DEPTH_V)) begin
          state_d = S_START;
        end else if (!fifo_empty) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (run_pending_q) begin
          state_d = S_START;
        end
      end
      S_DRAIN: begin
        adjmat_we = 1'b1;
        pop       = 1'b1;
        if (run_pending_q && (drain_cnt_q == CAP_V)) begin
          drain_cnt_d = DEPTH_V;
          state_d     = S_IDLE;
        end else begin
          if (drain_cnt_q != CAP_V) begin
            drain_cnt_d = drain_cnt_q + ONE_V;
          end
          if (drain_last) begin
            state_d = S_IDLE;
          end
        end
      end
      S_START: begin
        bellman_reset = 1'b1;
        bellman_src_d = src_q;
        run_pending_d = 1'b0;
        drain_cnt_d   = '0;
        state_d       = S_RUN;
      end
      S_RUN: begin
        if (bus.bellman_done) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        result_valid = 1'b1;
        if (bus.result_ready) begin
          run_count_d = run_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving during START belongs to the next run.
    if (bus.run_req) begin
      run_pending_d = 1'b1;
      src_d         = bus.src_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      drain_cnt_q   <= '0;
      run_pending_q <= 1'b0;
      src_q         <= '0;
      bellman_src_q <= '0;
      run_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      drain_cnt_q   <= drain_cnt_d;
      run_pending_q <= run_pending_d;
      src_q         <= src_d;
      bellman_src_q <= bellman_src_d;
      run_count_q   <= run_count_d;
    end
  end

  assign bus.upd_ready      = !fifo_full;
  assign bus.adjmat_we      = adjmat_we;
  assign bus.adjmat_wr_row  = head_row;
  assign bus.adjmat_wr_col  = head_col;
  assign bus.adjmat_wr_data = head_weight;
  assign bus.bellman_reset  = bellman_reset;
  assign bus.bellman_src    = bellman_src_q;
  assign bus.result_valid   = result_valid;
  assign bus.run_count      = run_count_q;
  assign bus.busy           = (state_q != S_IDLE) || !fifo_empty || run_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_bellman_sched.sv
`default_nettype none
//==============================================================================
// tb_bellman_sched : directed/randomized bench for bellman_sched
// Revision: 1.0
//==============================================================================
module tb_bellman_sched;
  localparam int PW    = 3;
  localparam int WWID  = 7;
  localparam int DEPTH = 4;
  localparam int VW    = PW + 1;
  localparam int DW    = WWID + 1;
  localparam logic [DW-1:0] W_M5 = DW'(-5);

  typedef struct packed {
    logic [VW-1:0] row;
    logic [VW-1:0] col;
    logic [DW-1:0] w;
  } upd_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bellman_sched_if #(.PRED_WIDTH(PW), .WEIGHT_WIDTH(WWID)) bus ();

  bellman_sched #(
    .PRED_WIDTH  (PW),
    .WEIGHT_WIDTH(WWID),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   n_starts = 0;
  int   n_writes = 0;
  bit   in_run   = 1'b0;
  upd_t exp_q[$];
  upd_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted updates must reach the matrix in order, never while a run is live.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.adjmat_we) begin
        n_writes++;
        chk("we_during_run", 32'(in_run), 0);
        chk("we_with_result_valid", 32'(bus.result_valid), 0);
        chk("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_row", 32'(bus.adjmat_wr_row), 32'(mon_e.row));
          chk("wr_col", 32'(bus.adjmat_wr_col), 32'(mon_e.col));
          chk("wr_data", 32'(bus.adjmat_wr_data), 32'(mon_e.w));
        end
      end
      if (bus.bellman_reset) begin
        n_starts++;
        in_run = 1'b1;
      end
      if (bus.result_valid && bus.result_ready) in_run = 1'b0;
      if (bus.upd_valid && bus.upd_ready) begin
        exp_q.push_back({bus.upd_row, bus.upd_col, bus.upd_weight});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields();
    bus.upd_row    = VW'($urandom);
    bus.upd_col    = VW'($urandom);
    bus.upd_weight = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
  endtask

  task automatic push_upd(input logic [VW-1:0] r, input logic [VW-1:0] c, input logic [DW-1:0] w);
    bit ok;
    ok = 1'b0;
    bus.upd_valid  = 1'b1;
    bus.upd_row    = r;
    bus.upd_col    = c;
    bus.upd_weight = w;
    for (int k = 0; k < 40 && !ok; k++) begin
      bit acc;
      acc = bus.upd_ready;
      step();
      ok = acc;
    end
    bus.upd_valid = 1'b0;
    chk("push_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      step();
      k++;
    end
    chk(tag, 32'(bus.busy), 0);
    chk({tag, "_scoreboard"}, 32'(exp_q.size()), 0);
  endtask

  task automatic start_run(input logic [VW-1:0] s);
    bit seen;
    seen = 1'b0;
    bus.run_req = 1'b1;
    bus.src_in  = s;
    step();
    bus.run_req = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.bellman_reset) seen = 1'b1;
      else step();
    end
    chk("run_started", 32'(seen), 1);
    step();
    chk("run_src", 32'(bus.bellman_src), 32'(s));
  endtask

  task automatic finish_run(input logic [15:0] exp_count);
    bus.bellman_done = 1'b1;
    bus.result_ready = 1'b1;
    step();
    chk("report_valid", 32'(bus.result_valid), 1);
    step();
    bus.bellman_done = 1'b0;
    bus.result_ready = 1'b0;
    chk("run_count", 32'(bus.run_count), 32'(exp_count));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(bus.adjmat_we), 0);
    chk({tag, "_bellman_reset"}, 32'(bus.bellman_reset), 0);
    chk({tag, "_result_valid"}, 32'(bus.result_valid), 0);
    chk({tag, "_upd_ready"}, 32'(bus.upd_ready), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_run_count"}, 32'(bus.run_count), 0);
    chk({tag, "_bellman_src"}, 32'(bus.bellman_src), 0);
  endtask

  initial begin
    logic [VW-1:0] s, s2;
    int            n0, wcount;
    bit            started, ok, rv_seen;

    bus.upd_valid = 1'b0; bus.upd_row = '0; bus.upd_col = '0; bus.upd_weight = '0;
    bus.run_req = 1'b0; bus.src_in = '0; bus.bellman_done = 1'b0; bus.result_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Basic update: write appears two cycles after acceptance
    bus.upd_valid = 1'b1; bus.upd_row = 4'd2; bus.upd_col = 4'd3; bus.upd_weight = W_M5;
    step();
    bus.upd_valid = 1'b0;
    chk("basic_we_t1", 32'(bus.adjmat_we), 0);
    step();
    chk("basic_we_t2", 32'(bus.adjmat_we), 1);
    chk("basic_row", 32'(bus.adjmat_wr_row), 2);
    chk("basic_col", 32'(bus.adjmat_wr_col), 3);
    chk("basic_data", 32'(bus.adjmat_wr_data), 32'(W_M5));
    step();
    chk("basic_busy_low", 32'(bus.busy), 0);

    // Random updates with random gaps
    for (int i = 0; i < 12; i++) begin
      push_upd(VW'($urandom), VW'($urandom), ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    wait_idle("rand_drain");

    // Run and handshake
    bus.run_req = 1'b1; bus.src_in = 4'd1;
    step();
    bus.run_req = 1'b0;
    chk("start_c1", 32'(bus.bellman_reset), 0);
    step();
    chk("start_c2", 32'(bus.bellman_reset), 1);
    step();
    chk("start_c3", 32'(bus.bellman_reset), 0);
    chk("start_src", 32'(bus.bellman_src), 1);
    rv_seen = 1'b0;
    repeat (50) begin
      step();
      rv_seen |= bus.result_valid;
    end
    chk("no_valid_before_done", 32'(rv_seen), 0);
    bus.bellman_done = 1'b1;
    step();
    chk("valid_on_done", 32'(bus.result_valid), 1);
    repeat (3) begin
      step();
      chk("valid_held", 32'(bus.result_valid), 1);
      chk("count_held", 32'(bus.run_count), 0);
    end
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
    bus.bellman_done = 1'b0;
    chk("valid_after_hs", 32'(bus.result_valid), 0);
    chk("run_count_1", 32'(bus.run_count), 1);

    // Full FIFO while running
    s = VW'($urandom);
    start_run(s);
    for (int i = 0; i < DEPTH; i++) push_upd(VW'($urandom), VW'($urandom), DW'($urandom));
    chk("full_ready_low", 32'(bus.upd_ready), 0);
    bus.upd_valid = 1'b1;
    rand_fields();
    repeat (3) begin
      step();
      chk("full_hold", 32'(bus.upd_ready), 0);
    end
    finish_run(16'd2);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      bit acc;
      acc = bus.upd_ready;
      step();
      ok = acc;
    end
    bus.upd_valid = 1'b0;
    chk("fifth_accepted", 32'(ok), 1);
    wait_idle("full_drain");

    // Drain cap: continuous refill while a run is pending
    s = VW'($urandom);
    bus.upd_valid = 1'b1;
    rand_fields();
    wcount  = 0;
    started = 1'b0;
    for (int k = 0; k < 60 && !started; k++) begin
      bit acc;
      bus.run_req = (k == 6);
      bus.src_in  = s;
      acc = bus.upd_ready;
      step();
      if (acc) rand_fields();
      if (k >= 6) begin
        if (bus.bellman_reset) started = 1'b1;
        else if (bus.adjmat_we) wcount++;
      end
    end
    bus.run_req = 1'b0;
    chk("cap_started", 32'(started), 1);
    chk("cap_writes_le_depth", 32'(wcount <= DEPTH), 1);
    for (int k = 0; k < 8; k++) begin
      bit acc;
      acc = bus.upd_ready;
      step();
      if (acc) rand_fields();
    end
    bus.upd_valid = 1'b0;
    chk("cap_src", 32'(bus.bellman_src), 32'(s));
    finish_run(16'd3);
    wait_idle("cap_drain");

    // Coalesced requests, then a request during RUN
    n0 = n_starts;
    bus.run_req = 1'b1; bus.src_in = 4'd2;
    step();
    bus.src_in = 4'd4;
    step();
    bus.run_req = 1'b0;
    chk("coal_start", 32'(bus.bellman_reset), 1);
    step();
    chk("coal_src", 32'(bus.bellman_src), 4);
    s2 = VW'($urandom_range(5, 15));
    bus.run_req = 1'b1; bus.src_in = s2;
    step();
    bus.run_req = 1'b0;
    repeat (5) step();
    chk("coal_one_start", 32'(n_starts - n0), 1);
    finish_run(16'd4);
    started = 1'b0;
    for (int k = 0; k < 20 && !started; k++) begin
      step();
      if (bus.bellman_reset) started = 1'b1;
    end
    chk("second_run_started", 32'(started), 1);
    step();
    chk("second_run_src", 32'(bus.bellman_src), 32'(s2));
    finish_run(16'd5);
    chk("two_starts", 32'(n_starts - n0), 2);
    wait_idle("coal_idle");

    // Reset mid-run, then a stale done must not report
    start_run(VW'($urandom));
    push_upd(VW'($urandom), VW'($urandom), DW'($urandom));
    push_upd(VW'($urandom), VW'($urandom), DW'($urandom));
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrun_reset");
    exp_q.delete();
    in_run = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.bellman_done = 1'b1;
    repeat (6) begin
      step();
      chk("stale_done_no_valid", 32'(bus.result_valid), 0);
    end
    bus.bellman_done = 1'b0;
    chk("post_reset_count", 32'(bus.run_count), 0);
    chk("post_reset_busy", 32'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
